// File: rtl/regfile_scoreboard_if.sv
// ----------------------------------------------------------------------------
// regfile_scoreboard_if
// Bundle between the ID/WB stages and the decode-side register file with
// pending-write scoreboard.
//   master : ID/WB side. Drives read addresses, issue info and write-back.
//            Receives operands, stall and the sticky underflow flag.
//   slave  : register file / scoreboard side.
// Signals:
//   rs, rt, rs_used, rt_used            source operand addresses and use bits
//   issue, issue_write_reg,
//   issue_reg_dest                      instruction presented for EXE
//   wb_write_reg, wb_reg_dest, wb_data  write-back port
//   qa, qb                              operands (combinational, WB bypass)
//   stall                               hold ID, bubble into ID/EXE
//   err_underflow                       sticky: WB to a non-pending register
// ----------------------------------------------------------------------------
interface regfile_scoreboard_if;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        rs_used;
    logic        rt_used;
    logic        issue;
    logic        issue_write_reg;
    logic [4:0]  issue_reg_dest;
    logic        wb_write_reg;
    logic [4:0]  wb_reg_dest;
    logic [31:0] wb_data;
    logic [31:0] qa;
    logic [31:0] qb;
    logic        stall;
    logic        err_underflow;

    modport master (
        output rs, rt, rs_used, rt_used,
        output issue, issue_write_reg, issue_reg_dest,
        output wb_write_reg, wb_reg_dest, wb_data,
        input  qa, qb, stall, err_underflow
    );

    modport slave (
        input  rs, rt, rs_used, rt_used,
        input  issue, issue_write_reg, issue_reg_dest,
        input  wb_write_reg, wb_reg_dest, wb_data,
        output qa, qb, stall, err_underflow
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// ----------------------------------------------------------------------------
// regfile_scoreboard
// 32x32 general register file (r0 hardwired zero) with same-cycle WB bypass
// and a per-register count of in-flight writes. Stall is raised when an
// issuing instruction reads a register whose producer is still in flight, or
// when its destination already has MAXPEND writes outstanding.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; clears registers, scoreboard, error flag
//   sb     regfile_scoreboard_if.slave (operands, issue, write-back, status)
// ----------------------------------------------------------------------------

// One pending-write counter. inc and dec together leave the count unchanged;
// the caller guarantees inc never hits a full counter and dec never an empty one.
module regfile_scoreboard_cnt #(
    parameter int PW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          dec,
    output logic [PW-1:0] pend
);
    logic [PW-1:0] pend_q, pend_d;

    always_comb begin
        pend_d = pend_q;
        if (inc && !dec)      pend_d = pend_q + PW'(1);
        else if (dec && !inc) pend_d = pend_q - PW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pend_q <= '0;
        else       pend_q <= pend_d;
    end

    assign pend = pend_q;
endmodule

module regfile_scoreboard #(
    parameter int NREGS   = 32,
    parameter int MAXPEND = 3
) (
    input logic                 clk,
    input logic                 reset,
    regfile_scoreboard_if.slave sb
);
    localparam int PW = $clog2(MAXPEND + 1);

    logic [NREGS-1:0][31:0]   regs_q, regs_d;
    logic [NREGS-1:0][PW-1:0] pend;
    logic [NREGS-1:0]         wb_fwd;
    logic                     err_underflow_q, err_underflow_d;
    logic                     rs_hit, rt_hit, waw_full, stall_raw, acc;

    // Pending count minus a same-cycle WB retirement, floored at zero, is
    // nonzero when more than one write is outstanding, or exactly one that
    // is not retiring right now.
    function automatic logic eff_busy(input logic [PW-1:0] p, input logic fwd);
        return (p > PW'(1)) || ((p == PW'(1)) && !fwd);
    endfunction

    // ---------------- scoreboard ----------------
    for (genvar r = 0; r < NREGS; r++) begin : g_reg
        localparam logic [4:0] RIDX = 5'(r);
        assign wb_fwd[r] = sb.wb_write_reg && (sb.wb_reg_dest == RIDX);
        if (r == 0) begin : g_zero
            assign pend[r] = '0;
        end else begin : g_cnt
            logic inc, dec;
            assign inc = acc && sb.issue_write_reg && (sb.issue_reg_dest == RIDX);
            assign dec = wb_fwd[r] && (pend[r] != '0);
            regfile_scoreboard_cnt #(.PW(PW)) u_cnt (
                .clk   (clk),
                .reset (reset),
                .inc   (inc),
                .dec   (dec),
                .pend  (pend[r])
            );
        end
    end

    // WAW full check looks at raw pend, not pend minus retirement: a WB to a
    // full destination still costs one stall cycle.
    always_comb begin
        rs_hit    = sb.rs_used && (sb.rs != 5'd0) && eff_busy(pend[sb.rs], wb_fwd[sb.rs]);
        rt_hit    = sb.rt_used && (sb.rt != 5'd0) && eff_busy(pend[sb.rt], wb_fwd[sb.rt]);
        waw_full  = sb.issue_write_reg && (sb.issue_reg_dest != 5'd0) &&
                    (pend[sb.issue_reg_dest] == PW'(MAXPEND));
        stall_raw = sb.issue && (rs_hit || rt_hit || waw_full);
        acc       = sb.issue && !stall_raw;
    end

    // ---------------- register array ----------------
    always_comb begin
        regs_d = regs_q;
        if (sb.wb_write_reg && (sb.wb_reg_dest != 5'd0))
            regs_d[sb.wb_reg_dest] = sb.wb_data;
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) regs_q <= '0;
        else       regs_q <= regs_d;
    end

    // ---------------- underflow flag ----------------
    always_comb begin
        err_underflow_d = err_underflow_q;
        if (sb.wb_write_reg && (sb.wb_reg_dest != 5'd0) && (pend[sb.wb_reg_dest] == '0))
            err_underflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_underflow_q <= 1'b0;
        else       err_underflow_q <= err_underflow_d;
    end

    // ---------------- outputs ----------------
    // Reset gates the bypass path too, so operands read zero while reset is high.
    always_comb begin
        sb.qa = '0;
        sb.qb = '0;
        if (!reset && (sb.rs != 5'd0)) sb.qa = wb_fwd[sb.rs] ? sb.wb_data : regs_q[sb.rs];
        if (!reset && (sb.rt != 5'd0)) sb.qb = wb_fwd[sb.rt] ? sb.wb_data : regs_q[sb.rt];
        sb.stall         = stall_raw && !reset;
        sb.err_underflow = err_underflow_q;
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    regfile_scoreboard_if bus();

    regfile_scoreboard #(.NREGS(32), .MAXPEND(3)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (bus)
    );

    localparam int S_QA = 0, S_QB = 1, S_STALL = 2, S_ERR = 3;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic void push(string name, int sel, logic [31:0] val);
        exp_t e;
        e.name = name; e.sel = sel; e.val = val;
        sbq.push_back(e);
    endfunction

    function automatic logic [31:0] observe(int sel);
        case (sel)
            S_QA:    return bus.qa;
            S_QB:    return bus.qb;
            S_STALL: return {31'd0, bus.stall};
            default: return {31'd0, bus.err_underflow};
        endcase
    endfunction

    task automatic idle();
        bus.rs = 5'd0; bus.rt = 5'd0; bus.rs_used = 1'b0; bus.rt_used = 1'b0;
        bus.issue = 1'b0; bus.issue_write_reg = 1'b0; bus.issue_reg_dest = 5'd0;
        bus.wb_write_reg = 1'b0; bus.wb_reg_dest = 5'd0; bus.wb_data = 32'd0;
    endtask

    task automatic iss(input logic wr, input logic [4:0] dest);
        bus.issue = 1'b1; bus.issue_write_reg = wr; bus.issue_reg_dest = dest;
    endtask

    task automatic wb(input logic [4:0] dest, input logic [31:0] data);
        bus.wb_write_reg = 1'b1; bus.wb_reg_dest = dest; bus.wb_data = data;
    endtask

    task automatic do_reset();
        @(negedge clk); idle(); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e; logic [31:0] obs;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); idle();
            case (k)
                0: begin
                    reset = 1'b1; bus.rs = 5'd5; bus.rt = 5'd5; bus.rs_used = 1'b1;
                    iss(1'b1, 5'd5); wb(5'd5, 32'hAA);
                    push("rst_hi_qa", S_QA, 0); push("rst_hi_qb", S_QB, 0);
                    push("rst_hi_stall", S_STALL, 0); push("rst_hi_err", S_ERR, 0);
                end
                default: begin
                    reset = 1'b0; bus.rs = 5'd5; bus.rt = 5'd0;
                    push("rst_qa", S_QA, 0); push("rst_qb", S_QB, 0);
                    push("rst_stall", S_STALL, 0); push("rst_err", S_ERR, 0);
                end
            endcase
            #1;
            while (sbq.size() > 0) begin
                e = sbq.pop_front(); obs = observe(e.sel); vectors++;
                if (obs !== e.val) begin
                    miscompares++;
                    $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", e.name, k, obs, e.val);
                end
            end
        end
    endtask

    task automatic test_write_read();
        exp_t e; logic [31:0] obs;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); idle();
            case (k)
                0: begin wb(5'd7, 32'hDEADBEEF); bus.rs = 5'd7;
                   push("wr_bypass_qa", S_QA, 32'hDEADBEEF); push("wr_err0", S_ERR, 0); end
                1: begin bus.rs = 5'd7; bus.rt = 5'd7;
                   push("wr_array_qa", S_QA, 32'hDEADBEEF); push("wr_array_qb", S_QB, 32'hDEADBEEF);
                   push("wr_underflow_err", S_ERR, 1); end
                2: begin wb(5'd0, 32'h1234);
                   push("wr_r0_bypass_qa", S_QA, 0); push("wr_r0_bypass_qb", S_QB, 0); end
                default: begin bus.rt = 5'd7;
                   push("wr_r0_qa", S_QA, 0); push("wr_r7_keep_qb", S_QB, 32'hDEADBEEF); end
            endcase
            #1;
            while (sbq.size() > 0) begin
                e = sbq.pop_front(); obs = observe(e.sel); vectors++;
                if (obs !== e.val) begin
                    miscompares++;
                    $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", e.name, k, obs, e.val);
                end
            end
        end
    endtask

    task automatic test_raw();
        exp_t e; logic [31:0] obs;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            @(negedge clk); idle();
            case (k)
                0: begin iss(1'b1, 5'd3); push("raw_prod_stall", S_STALL, 0); end
                1, 2: begin iss(1'b0, 5'd0); bus.rs = 5'd3; bus.rs_used = 1'b1;
                   push("raw_pending_stall", S_STALL, 1); end
                3: begin iss(1'b0, 5'd0); bus.rs = 5'd3; bus.rs_used = 1'b1; wb(5'd3, 32'h55);
                   push("raw_wb_stall", S_STALL, 0); push("raw_wb_qa", S_QA, 32'h55); end
                4: begin iss(1'b0, 5'd0); bus.rs = 5'd3; bus.rs_used = 1'b1;
                   push("raw_cleared_stall", S_STALL, 0); push("raw_cleared_qa", S_QA, 32'h55);
                   push("raw_err", S_ERR, 0); end
                5: begin iss(1'b1, 5'd3); push("raw_prod2_stall", S_STALL, 0); end
                6: begin iss(1'b0, 5'd0); bus.rs = 5'd3; bus.rt = 5'd3;
                   push("raw_unused_stall", S_STALL, 0); end
                7: begin iss(1'b0, 5'd0); bus.rt = 5'd3; bus.rt_used = 1'b1;
                   push("raw_rt_stall", S_STALL, 1); end
                default: begin bus.rt = 5'd3; wb(5'd3, 32'h66);
                   push("raw_rt_qb", S_QB, 32'h66); push("raw_idle_stall", S_STALL, 0);
                   push("raw_err2", S_ERR, 0); end
            endcase
            #1;
            while (sbq.size() > 0) begin
                e = sbq.pop_front(); obs = observe(e.sel); vectors++;
                if (obs !== e.val) begin
                    miscompares++;
                    $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", e.name, k, obs, e.val);
                end
            end
        end
    endtask

    task automatic test_waw_saturation();
        exp_t e; logic [31:0] obs;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); idle();
            case (k)
                0, 1, 2: begin iss(1'b1, 5'd9); push("waw_fill_stall", S_STALL, 0); end
                3: begin iss(1'b1, 5'd9); push("waw_full_stall", S_STALL, 1); end
                4: begin iss(1'b1, 5'd9); wb(5'd9, 32'h99);
                   push("waw_full_wb_stall", S_STALL, 1); end
                5: begin iss(1'b1, 5'd9); push("waw_accept_stall", S_STALL, 0); end
                6: begin iss(1'b1, 5'd9); push("waw_refull_stall", S_STALL, 1); end
                default: begin iss(1'b0, 5'd0); bus.rs = 5'd9; bus.rs_used = 1'b1; wb(5'd9, 32'h9A);
                   push("waw_eff2_stall", S_STALL, 1); push("waw_err", S_ERR, 0); end
            endcase
            #1;
            while (sbq.size() > 0) begin
                e = sbq.pop_front(); obs = observe(e.sel); vectors++;
                if (obs !== e.val) begin
                    miscompares++;
                    $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", e.name, k, obs, e.val);
                end
            end
        end
    endtask

    task automatic test_simul_inc_dec();
        exp_t e; logic [31:0] obs;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); idle();
            case (k)
                0: begin iss(1'b1, 5'd4); push("sim_prod_stall", S_STALL, 0); end
                1: begin iss(1'b1, 5'd4); wb(5'd4, 32'h44);
                   push("sim_incdec_stall", S_STALL, 0); end
                2: begin iss(1'b0, 5'd0); bus.rs = 5'd4; bus.rs_used = 1'b1;
                   push("sim_still1_stall", S_STALL, 1); push("sim_err", S_ERR, 0); end
                3: begin iss(1'b0, 5'd0); bus.rs = 5'd4; bus.rs_used = 1'b1; wb(5'd4, 32'h45);
                   push("sim_wb_stall", S_STALL, 0); push("sim_wb_qa", S_QA, 32'h45); end
                default: begin iss(1'b0, 5'd0); bus.rs = 5'd4; bus.rs_used = 1'b1;
                   push("sim_clear_stall", S_STALL, 0); push("sim_clear_qa", S_QA, 32'h45);
                   push("sim_err2", S_ERR, 0); end
            endcase
            #1;
            while (sbq.size() > 0) begin
                e = sbq.pop_front(); obs = observe(e.sel); vectors++;
                if (obs !== e.val) begin
                    miscompares++;
                    $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", e.name, k, obs, e.val);
                end
            end
        end
    endtask

    task automatic test_underflow_reset();
        exp_t e; logic [31:0] obs;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); idle();
            case (k)
                0: begin wb(5'd12, 32'h12); bus.rs = 5'd12;
                   push("uf_bypass_qa", S_QA, 32'h12); push("uf_err_pre", S_ERR, 0); end
                1: begin bus.rs = 5'd12;
                   push("uf_written_qa", S_QA, 32'h12); push("uf_err_set", S_ERR, 1); end
                2: begin iss(1'b1, 5'd12); push("uf_prod_stall", S_STALL, 0);
                   push("uf_err_hold", S_ERR, 1); end
                3: begin iss(1'b0, 5'd0); bus.rs = 5'd12; bus.rs_used = 1'b1;
                   push("uf_stall", S_STALL, 1); push("uf_err_hold2", S_ERR, 1); end
                4: begin iss(1'b0, 5'd0); bus.rs = 5'd12; bus.rs_used = 1'b1; reset = 1'b1;
                   push("midrst_stall", S_STALL, 0); push("midrst_err", S_ERR, 0);
                   push("midrst_qa", S_QA, 0); end
                default: begin iss(1'b0, 5'd0); bus.rs = 5'd12; bus.rs_used = 1'b1; reset = 1'b0;
                   push("postrst_stall", S_STALL, 0); push("postrst_err", S_ERR, 0);
                   push("postrst_qa", S_QA, 0); end
            endcase
            #1;
            while (sbq.size() > 0) begin
                e = sbq.pop_front(); obs = observe(e.sel); vectors++;
                if (obs !== e.val) begin
                    miscompares++;
                    $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", e.name, k, obs, e.val);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        test_reset();
        test_write_read();
        test_raw();
        test_waw_saturation();
        test_simul_inc_dec();
        test_underflow_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Decode-side source of the qa/qb operands and reg_dest tracking that the ID/EXE pipeline register forwards into EXE; it is the writer-facing end of that interface.
- Holds the 32x32 general register file, accepts write-back from WB, and keeps a per-register pending-write scoreboard.
- Raises stall when an issuing instruction would read a register whose producer is still in flight (EXE/MEM/WB).

Parameters:
- NREGS, 32, number of architectural registers (r0 hardwired zero).
- MAXPEND, 3, maximum in-flight writes tracked per register; counter width 2.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears registers, scoreboard and error flag.
- rs  input  5  source register A address.
- rt  input  5  source register B address.
- rs_used  input  1  instruction in ID reads rs.
- rt_used  input  1  instruction in ID reads rt (0 for immediate-form ALU ops).
- issue  input  1  ID instruction is valid and would advance to EXE this cycle.
- issue_write_reg  input  1  issuing instruction writes a register.
- issue_reg_dest  input  5  destination register of issuing instruction.
- wb_write_reg  input  1  WB stage writes the register file this cycle.
- wb_reg_dest  input  5  WB destination.
- wb_data  input  32  WB write data.
- qa  output  32  value of rs (combinational, with WB bypass).
- qb  output  32  value of rt (combinational, with WB bypass).
- stall  output  1  combinational; ID must hold, ID/EXE receives a bubble.
- err_underflow  output  1  sticky: WB wrote a register with zero pending count.

Behaviour:
- Reset (async, any time, including mid-stall): regs[1..31]=0, pend[0..31]=0, err_underflow=0. With reset high: qa=qb=0 for any address, stall=0, err_underflow=0.
- Read: qa = 0 if rs==0; else wb_data if wb_write_reg && wb_reg_dest==rs; else regs[rs]. qb likewise with rt. Same-cycle write-through; no read latency.
- Write: on clk rising edge, if wb_write_reg && wb_reg_dest!=0, regs[wb_reg_dest]<=wb_data. Writes to r0 are ignored; r0 is never pending.
- wb_fwd(r) = wb_write_reg && wb_reg_dest==r.
- eff(r) = pend[r] - (wb_fwd(r) ? 1 : 0), floored at 0.
- stall = issue && ((rs_used && rs!=0 && eff(rs)!=0) || (rt_used && rt!=0 && eff(rt)!=0) || (issue_write_reg && issue_reg_dest!=0 && pend[issue_reg_dest]==MAXPEND)).
- Accepted issue: acc = issue && !stall.
- Scoreboard update per register r!=0, each edge:
  - inc = acc && issue_write_reg && issue_reg_dest==r.
  - dec = wb_fwd(r) && pend[r]!=0.
  - inc&&!dec: +1; dec&&!inc: -1; both or neither: unchanged.
  - Never wraps: saturation is prevented by the stall term; underflow is prevented by the dec guard.
- err_underflow <= 1 on any edge where wb_write_reg && wb_reg_dest!=0 && pend[wb_reg_dest]==0. The write still occurs. The flag holds until reset.
- Stall is purely combinational from current state and inputs. The block has no handshake state of its own; ID re-presents the same instruction while stall=1.
- Simultaneous issue and WB to the same dest with pend==MAXPEND: the stall term uses pend, not eff, so it stalls one extra cycle (conservative, required).

Test Plan:
- Reset then read: reset pulse, rs=5, rt=0 -> qa=0, qb=0, stall=0, err_underflow=0.
- Write/read and bypass: wb r7=0xDEADBEEF, rs=7 the same cycle -> qa=0xDEADBEEF combinationally; next cycle with wb idle -> qa=0xDEADBEEF from array. wb r0=0x1234 -> qa(rs=0)=0.
- RAW interlock:
  - Setup: issue writes r3 (pend=1); next cycle, ID issues with rs=3, rs_used=1.
  - While r3 is pending: stall=1 each cycle.
  - The cycle WB writes r3=0x55: stall=0 and qa=0x55; pend[3]=0 after the edge.
  - Same sequence with rs_used=0: stall=0 throughout.
- WAW saturation: three accepted issues to r9 -> pend=3; fourth issue to r9 -> stall=1 until one WB to r9, then accepted; pend stays 3.
- Simultaneous inc/dec: pend[4]=1; accepted issue to r4 and WB r4 in the same cycle -> pend[4]=1 after the edge, no err.
- Underflow and mid-op reset:
  - WB r12 with pend=0 -> regs[12] written, err_underflow=1 and stays 1.
  - Reset asserted mid-stall (between edges): stall=0, err=0 and all pend=0 immediately.
